// File: rtl/wb_dma_copy.sv
// Wishbone pipelined block copier: read word, write word, repeat until the count is exhausted.
// Optional ack-timeout abort is built when WB_DMA_TIMEOUT_EN is defined.
module wb_dma_copy #(
  parameter int LEN_WIDTH = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [31:0]          i_src,
  input  logic [31:0]          i_dst,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [31:0]          o_addr,
  output logic [31:0]          o_data,
  input  logic [31:0]          i_data,
  output logic                 o_we,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  state_t               state, state_nx;
  logic [31:0]          src, dst, data_q;
  logic [LEN_WIDTH-1:0] rem;
  logic                 tmo;
  logic                 start_ok;
  logic                 unused_lsb;

  assign start_ok   = (state == IDLE) && i_start;
  assign unused_lsb = ^{i_src[1:0], i_dst[1:0]};

`ifdef WB_DMA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          err;
  logic          in_wait;

  assign in_wait = (state == RD_WAIT) || (state == WR_WAIT);
  // An ack in the final allowed cycle still wins over the abort.
  assign tmo     = in_wait && !i_wb_ack && (cnt == CW'(TIMEOUT - 1));
  assign o_err   = err;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= in_wait ? cnt + CW'(1) : '0;
      if (start_ok)
        err <= 1'b0;
      else if (tmo)
        err <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo            = 1'b0;
  assign o_err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = (i_len == '0) ? DONE : RD_REQ;
      RD_REQ:  if (!i_wb_stall) state_nx = RD_WAIT;
      RD_WAIT: if (tmo) state_nx = DONE;
               else if (i_wb_ack) state_nx = WR_REQ;
      WR_REQ:  if (!i_wb_stall) state_nx = WR_WAIT;
      WR_WAIT: if (tmo) state_nx = DONE;
               else if (i_wb_ack) state_nx = (rem == LEN_WIDTH'(1)) ? DONE : RD_REQ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src    <= '0;
      dst    <= '0;
      rem    <= '0;
      data_q <= '0;
    end else begin
      if (start_ok) begin
        src <= {i_src[31:2], 2'b00};
        dst <= {i_dst[31:2], 2'b00};
        rem <= i_len;
      end
      if (state == RD_WAIT && i_wb_ack)
        data_q <= i_data;
      if (state == WR_WAIT && i_wb_ack) begin
        src <= src + 32'd4;
        dst <= dst + 32'd4;
        rem <= rem - LEN_WIDTH'(1);
      end
    end
  end

  assign o_data = data_q;

  always_comb begin
    o_busy   = (state != IDLE);
    o_done   = (state == DONE);
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_we     = 1'b0;
    o_addr   = '0;
    case (state)
      RD_REQ:  begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; o_addr = src; end
      RD_WAIT: begin o_wb_cyc = 1'b1; o_addr = src; end
      WR_REQ:  begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; o_we = 1'b1; o_addr = dst; end
      WR_WAIT: begin o_wb_cyc = 1'b1; o_we = 1'b1; o_addr = dst; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Scoreboarded bench for wb_dma_copy: a memory responder with random stall, and an
// in-order queue of expected bus transfers derived from the copy request.
module tb_wb_dma_copy;

`ifdef WB_DMA_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_src = '0, i_dst = '0;
  logic [15:0] i_len = '0;
  logic        o_busy, o_done, o_err, o_we, o_wb_cyc, o_wb_stb;
  logic [31:0] o_addr, o_data;
  logic [31:0] i_data = '0;
  logic        i_wb_stall = 1'b0, i_wb_ack = 1'b0;

  int          n_tests = 0, n_fail = 0;
  xact_t       exp_q[$];
  logic [31:0] mem[logic [31:0]];
  int          stall_pct = 0;
  bit          no_ack = 0, late_ack = 0, saw_cyc = 0;

  wb_dma_copy #(.LEN_WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_src(i_src), .i_dst(i_dst), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_addr(o_addr), .o_data(o_data),
    .i_data(i_data), .o_we(o_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hdead0000 ^ a);
  endfunction

  // Responder and monitor: decisions made at negedge apply to the following posedge.
  bit          ack_pend = 0, prev_stalled = 0;
  logic [31:0] pend_data = '0, prev_addr = '0, prev_data = '0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      ack_pend     = 0;
      prev_stalled = 0;
      i_wb_ack     = 1'b0;
      i_wb_stall   = 1'b0;
    end else begin
      i_wb_ack = ack_pend || late_ack;
      i_data   = pend_data;
      ack_pend = 0;
      late_ack = 0;
      if (prev_stalled) begin
        check("stall_hold_stb", {31'd0, o_wb_stb}, 32'd1);
        check("stall_hold_addr", o_addr, prev_addr);
        check("stall_hold_we", {31'd0, o_we}, {31'd0, prev_we});
        check("stall_hold_data", o_data, prev_data);
      end
      i_wb_stall   = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
      prev_stalled = o_wb_stb && i_wb_stall;
      prev_addr    = o_addr;
      prev_we      = o_we;
      prev_data    = o_data;
      if (o_wb_cyc) saw_cyc = 1;
      if (o_wb_stb && !i_wb_stall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", o_addr, 32'hxxxxxxxx);
        end else begin
          xact_t e;
          e = exp_q.pop_front();
          check("xact_we", {31'd0, o_we}, {31'd0, e.we});
          check("xact_addr", o_addr, e.addr);
          if (e.we) check("xact_wdata", o_data, e.data);
        end
        if (o_we) mem[o_addr] = o_data;
        else      pend_data   = mem_rd(o_addr);
        ack_pend = !no_ack;
      end
    end
  end

  // Reference: each word k is one read of src+4k followed by one write of that word to dst+4k.
  task automatic push_model(input logic [31:0] s, input logic [31:0] d, input int len);
    for (int k = 0; k < len; k++) begin
      logic [31:0] w;
      w = $urandom;
      mem[s + 32'(4 * k)] = w;
      exp_q.push_back('{1'b0, s + 32'(4 * k), 32'd0});
      exp_q.push_back('{1'b1, d + 32'(4 * k), w});
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                          input int pct, input bit poke);
    int n;
    stall_pct = pct;
    push_model(s, d, len);
    @(negedge clk);
    saw_cyc = 0;
    i_src   = s | 32'($urandom_range(3));
    i_dst   = d | 32'($urandom_range(3));
    i_len   = 16'(len);
    i_start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      n++;
      if (poke && n == 5) begin
        i_start = 1'b1;
        i_src   = s + 32'h100;
        i_dst   = d + 32'h100;
        i_len   = 16'd3;
      end
    end while (!o_done && n < 4000);
    check("done_seen", {31'd0, o_done}, 32'd1);
    if (pct == 0) check("done_latency", 32'(n), 32'(4 * len + 1));
    check("busy_at_done", {31'd0, o_busy}, 32'd1);
    check("err_clear", {31'd0, o_err}, 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    if (len == 0) check("len0_no_cyc", {31'd0, saw_cyc}, 32'd0);
    @(negedge clk);
    check("idle_busy", {31'd0, o_busy}, 32'd0);
    check("idle_done", {31'd0, o_done}, 32'd0);
    check("idle_cyc", {31'd0, o_wb_cyc}, 32'd0);
    for (int k = 0; k < len; k++)
      check("copied_word", mem_rd(d + 32'(4 * k)), mem_rd(s + 32'(4 * k)));
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_we", {31'd0, o_we}, 32'd0);
    check("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("rst_stb", {31'd0, o_wb_stb}, 32'd0);
    check("rst_addr", o_addr, 32'd0);
    check("rst_data", o_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_copy(32'hb0000000, 32'hb0008000, 4, 0, 0);
    run_copy(32'hb0000040, 32'hb0008040, 0, 0, 0);
    run_copy(32'hb0000000, 32'hb0008000, 8, 50, 0);
    run_copy(32'hb0001000, 32'hb0009000, 6, 0, 1);
    run_copy(32'hfffffff8, 32'h10000000, 4, 0, 0);
    for (int t = 0; t < 6; t++)
      run_copy(32'h20000000 + {20'd0, 10'($urandom), 2'b00},
               32'h30000000 + {20'd0, 10'($urandom), 2'b00},
               $urandom_range(1, 5), $urandom_range(0, 70), 0);

    // Reset while waiting for the write ack of word 2.
    begin
      int n;
      stall_pct = 0;
      push_model(32'hb0002000, 32'hb000a000, 4);
      @(negedge clk);
      i_src = 32'hb0002000; i_dst = 32'hb000a000; i_len = 16'd4; i_start = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        i_start = 1'b0;
        n++;
      end while (!(o_wb_cyc && o_we && !o_wb_stb && o_addr == 32'hb000a008) && n < 200);
      check("reached_wr_wait_w2", o_addr, 32'hb000a008);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_cyc", {31'd0, o_wb_cyc}, 32'd0);
      check("midrst_stb", {31'd0, o_wb_stb}, 32'd0);
      check("midrst_busy", {31'd0, o_busy}, 32'd0);
      check("midrst_data", o_data, 32'd0);
      reset = 1'b0;
      exp_q.delete();
      late_ack = 1;
      repeat (3) begin
        @(negedge clk);
        check("late_ack_cyc", {31'd0, o_wb_cyc}, 32'd0);
        check("late_ack_busy", {31'd0, o_busy}, 32'd0);
        check("late_ack_done", {31'd0, o_done}, 32'd0);
        check("late_ack_data", o_data, 32'd0);
      end
    end

`ifdef WB_DMA_TIMEOUT_EN
    begin
      int n;
      no_ack = 1;
      stall_pct = 0;
      push_model(32'hb0003000, 32'hb000b000, 1);
      @(negedge clk);
      i_src = 32'hb0003000; i_dst = 32'hb000b000; i_len = 16'd1; i_start = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        i_start = 1'b0;
        n++;
      end while (!o_done && n < 100);
      check("tmo_latency", 32'(n), 32'd10);
      check("tmo_err", {31'd0, o_err}, 32'd1);
      check("tmo_cyc", {31'd0, o_wb_cyc}, 32'd0);
      no_ack = 0;
      exp_q.delete();
      @(negedge clk);
      check("tmo_err_sticky", {31'd0, o_err}, 32'd1);
      run_copy(32'hb0003000, 32'hb000b000, 1, 0, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
